// File: rtl/weighted_packet_scheduler_if.sv
// Bundle of channel inputs, merged output stream, weight config and status
// for the weighted packet scheduler. master = traffic/config source,
// slave = scheduler.
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 16
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 32
`endif

interface weighted_packet_scheduler_if #(
    parameter int unsigned CHNL_NUM     = 4,
    parameter int unsigned WEIGHT_WIDTH = 4
);
    // requester channels
    logic [CHNL_NUM-1:0]                 i_chnl_valid;
    logic [CHNL_NUM*`PKT_HEAD_WIDTH-1:0] iv_chnl_head;
    logic [CHNL_NUM*`PKT_DATA_WIDTH-1:0] iv_chnl_data;
    logic [CHNL_NUM-1:0]                 i_chnl_start;
    logic [CHNL_NUM-1:0]                 i_chnl_last;
    logic [CHNL_NUM-1:0]                 o_chnl_ready;
    // merged stream
    logic                                o_out_valid;
    logic [`PKT_HEAD_WIDTH-1:0]          ov_out_head;
    logic [`PKT_DATA_WIDTH-1:0]          ov_out_data;
    logic                                o_out_start;
    logic                                o_out_last;
    logic                                i_out_ready;
    // weight configuration
    logic                                i_cfg_wr_en;
    logic [1:0]                          iv_cfg_chnl;
    logic [WEIGHT_WIDTH-1:0]             iv_cfg_weight;
    // status
    logic [1:0]                          ov_cur_chnl;
    logic                                o_busy;

    modport master (
        output i_chnl_valid, iv_chnl_head, iv_chnl_data, i_chnl_start, i_chnl_last,
        output i_out_ready, i_cfg_wr_en, iv_cfg_chnl, iv_cfg_weight,
        input  o_chnl_ready, o_out_valid, ov_out_head, ov_out_data, o_out_start,
        input  o_out_last, ov_cur_chnl, o_busy
    );

    modport slave (
        input  i_chnl_valid, iv_chnl_head, iv_chnl_data, i_chnl_start, i_chnl_last,
        input  i_out_ready, i_cfg_wr_en, iv_cfg_chnl, iv_cfg_weight,
        output o_chnl_ready, o_out_valid, ov_out_head, ov_out_data, o_out_start,
        output o_out_last, ov_cur_chnl, o_busy
    );
endinterface

// File: rtl/weighted_packet_scheduler.sv
// Packet-granular weighted round-robin scheduler: merges CHNL_NUM packet
// streams into one, granting each channel up to weight[n] packets per turn.
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 16
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 32
`endif

module weighted_packet_scheduler #(
    parameter int unsigned CHNL_NUM     = 4,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    weighted_packet_scheduler_if.slave   bus
);
    localparam int unsigned HW = `PKT_HEAD_WIDTH;
    localparam int unsigned DW = `PKT_DATA_WIDTH;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [WEIGHT_WIDTH-1:0] burst_q, burst_d;
    logic                    turn_q, turn_d;
    logic [WEIGHT_WIDTH-1:0] weight_q [CHNL_NUM];
    logic [WEIGHT_WIDTH-1:0] weight_d [CHNL_NUM];

    logic [HW-1:0]           head_arr [CHNL_NUM];
    logic [DW-1:0]           data_arr [CHNL_NUM];
    logic                    keep;
    logic                    found;
    logic [1:0]              sel;
    logic [1:0]              cand;

    // Unpack the flat per-channel buses into indexable arrays
    always_comb begin
        for (int unsigned n = 0; n < CHNL_NUM; n++) begin
            head_arr[n] = bus.iv_chnl_head[n*HW +: HW];
            data_arr[n] = bus.iv_chnl_data[n*DW +: DW];
        end
    end

    // IDLE arbitration: stay on the pointer channel while its turn lasts,
    // otherwise search ptr+1 .. ptr+4 so a lone requester can re-win.
    // turn_q is clear only after reset, so the reset pointer (3) is never
    // "kept" and channel 0 is searched first.
    always_comb begin
        keep  = turn_q && bus.i_chnl_valid[ptr_q] && (weight_q[ptr_q] != '0) &&
                (burst_q < weight_q[ptr_q]);
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int unsigned k = 1; k <= CHNL_NUM; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && bus.i_chnl_valid[cand] && (weight_q[cand] != '0)) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next-state computation for FSM, pointer, burst counter and weights
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        burst_d  = burst_q;
        turn_d   = turn_q;
        weight_d = weight_q;
        if (bus.i_cfg_wr_en) begin
            weight_d[bus.iv_cfg_chnl] = bus.iv_cfg_weight;
        end
        case (state_q)
            IDLE: begin
                if (keep) begin
                    state_d = XFER;
                    gnt_d   = ptr_q;
                end else if (found) begin
                    state_d = XFER;
                    ptr_d   = sel;
                    gnt_d   = sel;
                    burst_d = '0;
                    turn_d  = 1'b1;
                end
            end
            XFER: begin
                if (bus.i_chnl_valid[gnt_q] && bus.i_chnl_last[gnt_q] && bus.i_out_ready) begin
                    state_d = IDLE;
                    if (burst_q != '1) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            gnt_q   <= '0;
            burst_q <= '0;
            turn_q  <= 1'b0;
            for (int unsigned n = 0; n < CHNL_NUM; n++) begin
                weight_q[n] <= WEIGHT_WIDTH'(1);
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            burst_q  <= burst_d;
            turn_q   <= turn_d;
            weight_q <= weight_d;
        end
    end

    // Output mux: mirror the granted channel in XFER, all zero in IDLE
    always_comb begin
        bus.o_out_valid  = 1'b0;
        bus.ov_out_head  = '0;
        bus.ov_out_data  = '0;
        bus.o_out_start  = 1'b0;
        bus.o_out_last   = 1'b0;
        bus.o_chnl_ready = '0;
        bus.o_busy       = (state_q == XFER);
        bus.ov_cur_chnl  = gnt_q;
        if (state_q == XFER) begin
            bus.o_out_valid         = bus.i_chnl_valid[gnt_q];
            bus.ov_out_head         = head_arr[gnt_q];
            bus.ov_out_data         = data_arr[gnt_q];
            bus.o_out_start         = bus.i_chnl_start[gnt_q];
            bus.o_out_last          = bus.i_chnl_last[gnt_q];
            bus.o_chnl_ready[gnt_q] = bus.i_out_ready;
        end
    end
endmodule

// File: tb/tb_weighted_packet_scheduler.sv
// Directed bench for weighted_packet_scheduler: grant order, weights,
// back-pressure, reset abandonment and live weight updates.
`ifndef PKT_HEAD_WIDTH
`define PKT_HEAD_WIDTH 16
`endif
`ifndef PKT_DATA_WIDTH
`define PKT_DATA_WIDTH 32
`endif

module tb_weighted_packet_scheduler;
    localparam int HW = `PKT_HEAD_WIDTH;
    localparam int DW = `PKT_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         got_n;
    logic [1:0] got_ch   [16];
    logic [HW-1:0] got_head [16];
    int         got_cyc  [16];

    weighted_packet_scheduler_if #(.CHNL_NUM(4), .WEIGHT_WIDTH(4)) bus ();

    weighted_packet_scheduler #(.CHNL_NUM(4), .WEIGHT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        bus.i_chnl_valid  = '0;
        bus.iv_chnl_head  = '0;
        bus.iv_chnl_data  = '0;
        bus.i_chnl_start  = '0;
        bus.i_chnl_last   = '0;
        bus.i_out_ready   = 1'b1;
        bus.i_cfg_wr_en   = 1'b0;
        bus.iv_cfg_chnl   = '0;
        bus.iv_cfg_weight = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // 1-beat packets on every channel in mask; head = A0+n, data = D000+n
    task automatic set_single(input logic [3:0] mask);
        bus.i_chnl_valid = mask;
        bus.i_chnl_start = mask;
        bus.i_chnl_last  = mask;
        for (int n = 0; n < 4; n++) begin
            bus.iv_chnl_head[n*HW +: HW] = HW'(16'hA0 + n);
            bus.iv_chnl_data[n*DW +: DW] = DW'(32'hD000 + n);
        end
    endtask

    task automatic wr_weight(input logic [1:0] ch, input logic [3:0] w);
        bus.i_cfg_wr_en   = 1'b1;
        bus.iv_cfg_chnl   = ch;
        bus.iv_cfg_weight = w;
        @(posedge clk);
        #1;
        bus.i_cfg_wr_en = 1'b0;
    endtask

    // Record accepted beats (granted channel, head, cycle index)
    task automatic run_grants(input int n, input int max_cycles);
        got_n = 0;
        for (int c = 0; c < max_cycles && got_n < n; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_out_valid && bus.i_out_ready) begin
                got_ch[got_n]   = bus.ov_cur_chnl;
                got_head[got_n] = bus.ov_out_head;
                got_cyc[got_n]  = c;
                got_n++;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        set_single(4'hF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_out_valid); end
        checks++; if (bus.o_chnl_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.o_chnl_ready); end
        checks++; if (bus.ov_out_head !== '0) begin errors++; $display("FAIL reset_head: got %h expected 0", bus.ov_out_head); end
        checks++; if (bus.ov_out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.ov_out_data); end
        checks++; if ({bus.o_out_start, bus.o_out_last} !== 2'b00) begin errors++; $display("FAIL reset_start_last: got %b expected 00", {bus.o_out_start, bus.o_out_last}); end
        checks++; if (bus.ov_cur_chnl !== 2'd0) begin errors++; $display("FAIL reset_cur_chnl: got %0d expected 0", bus.ov_cur_chnl); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        // no requesters: must stay idle
        clear_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL no_req_idle[%0d]: busy got %b expected 0", c, bus.o_busy); end
        end
    endtask

    task automatic test_round_robin();
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        do_reset();
        set_single(4'hF);
        #1;
        checks++; if ({bus.o_out_valid, bus.o_chnl_ready, bus.ov_out_head} !== '0) begin errors++; $display("FAIL idle_outputs: got valid=%b ready=%b head=%h expected all 0", bus.o_out_valid, bus.o_chnl_ready, bus.ov_out_head); end
        run_grants(5, 20);
        checks++; if (got_n !== 5) begin errors++; $display("FAIL rr_count: got %0d expected 5", got_n); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (got_ch[k] !== 2'(exp_ch[k])) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got_ch[k], exp_ch[k]); end
            checks++; if (got_head[k] !== HW'(16'hA0 + exp_ch[k])) begin errors++; $display("FAIL rr_head[%0d]: got %h expected %h", k, got_head[k], 16'hA0 + exp_ch[k]); end
            checks++; if (got_cyc[k] !== 2*k) begin errors++; $display("FAIL rr_spacing[%0d]: got cycle %0d expected %0d", k, got_cyc[k], 2*k); end
        end
    endtask

    task automatic test_weights();
        int exp_ch [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        do_reset();
        wr_weight(2'd0, 4'd3);
        set_single(4'hF);
        run_grants(9, 40);
        checks++; if (got_n !== 9) begin errors++; $display("FAIL wrr_count: got %0d expected 9", got_n); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (got_ch[k] !== 2'(exp_ch[k])) begin errors++; $display("FAIL wrr_order[%0d]: got %0d expected %0d", k, got_ch[k], exp_ch[k]); end
        end
    endtask

    task automatic test_zero_weight();
        int exp_ch [4] = '{1, 3, 1, 3};
        do_reset();
        wr_weight(2'd2, 4'd0);
        set_single(4'b1110);
        run_grants(4, 20);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL zw_count: got %0d expected 4", got_n); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got_ch[k] !== 2'(exp_ch[k])) begin errors++; $display("FAIL zw_order[%0d]: got %0d expected %0d", k, got_ch[k], exp_ch[k]); end
        end
    endtask

    task automatic test_backpressure();
        int  beat = 0;
        int  acc  = 0;
        logic rdy;
        do_reset();
        bus.iv_chnl_head[HW +: HW] = HW'(16'h5A);
        for (int c = 0; c < 40 && beat < 4; c++) begin
            rdy = ((c % 2) == 0);
            bus.i_out_ready  = rdy;
            bus.i_chnl_valid = 4'b0010;
            bus.i_chnl_start = (beat == 0) ? 4'b0010 : 4'b0000;
            bus.i_chnl_last  = (beat == 3) ? 4'b0010 : 4'b0000;
            bus.iv_chnl_data[DW +: DW] = DW'(32'hB000 + beat);
            #1;
            if (c >= 1) begin
                checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, bus.o_busy); end
                checks++; if (bus.o_chnl_ready !== (rdy ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, bus.o_chnl_ready, rdy ? 4'b0010 : 4'b0000); end
            end
            if (bus.o_chnl_ready[1]) begin
                checks++; if (bus.ov_out_data !== DW'(32'hB000 + beat)) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", beat, bus.ov_out_data, 32'hB000 + beat); end
                checks++; if ({bus.o_out_start, bus.o_out_last} !== {beat == 0, beat == 3}) begin errors++; $display("FAIL bp_marks[%0d]: got %b expected %b", beat, {bus.o_out_start, bus.o_out_last}, {beat == 0, beat == 3}); end
                acc++;
                beat++;
            end
            @(posedge clk);
            #1;
        end
        bus.i_chnl_valid = '0;
        bus.i_chnl_start = '0;
        bus.i_chnl_last  = '0;
        bus.i_out_ready  = 1'b1;
        #1;
        checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL bp_back_idle: busy got %b expected 0", bus.o_busy); end
        checks++; if (bus.o_chnl_ready !== 4'b0000) begin errors++; $display("FAIL bp_idle_ready: got %b expected 0000", bus.o_chnl_ready); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.i_out_ready  = 1'b1;
        bus.i_chnl_valid = 4'b0001;
        bus.i_chnl_start = 4'b0001;
        bus.iv_chnl_head[0 +: HW] = HW'(16'h77);
        bus.iv_chnl_data[0 +: DW] = DW'(32'hC000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.i_chnl_start = 4'b0000;
        bus.iv_chnl_data[0 +: DW] = DW'(32'hC001);
        #1;
        checks++; if (bus.ov_out_data !== DW'(32'hC001)) begin errors++; $display("FAIL mid_beat2: got %h expected %h", bus.ov_out_data, 32'hC001); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.o_out_valid, bus.o_chnl_ready, bus.o_busy} !== '0) begin errors++; $display("FAIL mid_rst_ctrl: got valid=%b ready=%b busy=%b expected 0", bus.o_out_valid, bus.o_chnl_ready, bus.o_busy); end
        checks++; if ({bus.ov_out_head, bus.ov_out_data, bus.ov_cur_chnl} !== '0) begin errors++; $display("FAIL mid_rst_bus: got head=%h data=%h cur=%0d expected 0", bus.ov_out_head, bus.ov_out_data, bus.ov_cur_chnl); end
        clear_inputs();
        set_single(4'b1100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_grants(2, 10);
        checks++; if (got_n !== 2) begin errors++; $display("FAIL mid_after_count: got %0d expected 2", got_n); end
        checks++; if (got_ch[0] !== 2'd2) begin errors++; $display("FAIL mid_first_grant: got %0d expected 2", got_ch[0]); end
        checks++; if (got_ch[1] !== 2'd3) begin errors++; $display("FAIL mid_second_grant: got %0d expected 3", got_ch[1]); end
    endtask

    task automatic test_weight_lower();
        logic [1:0] g [2];
        int n = 0;
        g[0] = 2'd3;
        g[1] = 2'd3;
        do_reset();
        wr_weight(2'd0, 4'd3);
        set_single(4'b0011);
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(posedge clk);
            #1;
            bus.i_cfg_wr_en = 1'b0;
            if (bus.o_out_valid && bus.i_out_ready) begin
                g[n] = bus.ov_cur_chnl;
                if (n == 0) begin
                    // lower channel 0 weight during its last beat
                    bus.i_cfg_wr_en   = 1'b1;
                    bus.iv_cfg_chnl   = 2'd0;
                    bus.iv_cfg_weight = 4'd1;
                end
                n++;
            end
        end
        bus.i_cfg_wr_en = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL wl_count: got %0d expected 2", n); end
        checks++; if (g[0] !== 2'd0) begin errors++; $display("FAIL wl_first: got %0d expected 0", g[0]); end
        checks++; if (g[1] !== 2'd1) begin errors++; $display("FAIL wl_second: got %0d expected 1", g[1]); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_weights();
        test_zero_weight();
        test_backpressure();
        test_reset_mid_packet();
        test_weight_lower();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
